icache: RTL

//  Direct-mapped, read-only instruction cache; responder side of the fetch I-cache interface.

---
 rtl/icache_pkg.sv | 40 ++++
 rtl/icache_data_ram.sv | 32 +++
 rtl/icache.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
//   icache_state_e  : controller states
//   ICACHE_*_DEF    : default geometry, used as module parameter defaults
//   icache_offset/index/tag : byte-address field extraction. Each helper takes the
//                             field widths, so it works for any geometry.
package icache_pkg;

  localparam int unsigned ICACHE_ADDR_W_DEF     = 32;
  localparam int unsigned ICACHE_NUM_LINES_DEF  = 64;
  localparam int unsigned ICACHE_LINE_WORDS_DEF = 4;
  localparam int unsigned ICACHE_OFF_W_DEF      = $clog2(ICACHE_LINE_WORDS_DEF);
  localparam int unsigned ICACHE_IDX_W_DEF      = $clog2(ICACHE_NUM_LINES_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_REFILL,
    ST_RESP
  } icache_state_e;

  // Word offset inside the line. Byte bits [1:0] are dropped.
  function automatic logic [63:0] icache_offset(input logic [63:0] addr,
                                                input int unsigned off_w);
    return (addr >> 2) & ((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [63:0] icache_index(input logic [63:0] addr,
                                               input int unsigned off_w,
                                               input int unsigned idx_w);
    return (addr >> (2 + off_w)) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] icache_tag(input logic [63:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: DEPTH x 32 bits.
// It has one synchronous write port and one asynchronous (combinational) read port.
// The array is not reset, because the valid bits in icache gate every use of the data.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : read data (combinational)
module icache_data_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// It answers word fetches from the fetch stage.
// On a miss it refills a whole line from memory, one word per beat, in ascending address order.
// Optional build macro: ICACHE_PERF_CNT_EN. It adds saturating hit and miss counters.
// Ports:
//   clk_i, rst_ni                         : clock, async active-low reset
//   ic_req_valid_i/ready_o/addr_i         : fetch request handshake
//   ic_rsp_valid_o/data_o                 : one-cycle response per accepted request
//   ic_flush_i                            : invalidates all lines and drops the pending response
//   mem_req_valid_o/addr_o/ready_i        : line refill request (line-aligned address)
//   mem_rsp_valid_i/data_i                : refill beats
//   hit_cnt_o, miss_cnt_o                 : lookup statistics (ICACHE_PERF_CNT_EN only)
module icache
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = ICACHE_ADDR_W_DEF,
  parameter int unsigned NUM_LINES  = ICACHE_NUM_LINES_DEF,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_req_ready_o,
  output logic              ic_rsp_valid_o,
  output logic [31:0]       ic_rsp_data_o,
  input  logic              ic_flush_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rsp_data_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int unsigned RAM_AW = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(LINE_WORDS - 1);

  icache_state_e          state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [OFF_W-1:0]       beat_q, beat_d;
  logic                   flushed_q, flushed_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [NUM_LINES];

  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_idx;
  logic [OFF_W-1:0]       req_off;
  logic                   hit;
  logic                   ready;
  logic                   rsp_valid;
  logic                   mem_req_valid;
  logic                   ram_we;
  logic                   tag_we;
  logic [31:0]            ram_rdata;

  assign req_off = OFF_W'(icache_offset(64'(addr_q), OFF_W));
  assign req_idx = IDX_W'(icache_index(64'(addr_q), OFF_W, IDX_W));
  assign req_tag = TAG_W'(icache_tag(64'(addr_q), OFF_W, IDX_W));
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beat_d        = beat_q;
    flushed_d     = flushed_q;
    valid_d       = valid_q;
    ready         = 1'b0;
    rsp_valid     = 1'b0;
    mem_req_valid = 1'b0;
    ram_we        = 1'b0;
    tag_we        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = !ic_flush_i;
        if (ic_req_valid_i && ready) begin
          addr_d  = ic_req_addr_i;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (ic_flush_i) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          rsp_valid = 1'b1;
          ready     = 1'b1;
          if (ic_req_valid_i) begin
            addr_d  = ic_req_addr_i;
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          flushed_d = 1'b0;
          state_d   = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        // A flush here must not retract the request. Record the flush, finish the
        // handshake, and drain the beats later without validating the line.
        mem_req_valid = 1'b1;
        if (ic_flush_i) begin
          flushed_d = 1'b1;
        end
        if (mem_req_ready_i) begin
          beat_d           = '0;
          valid_d[req_idx] = 1'b0;
          state_d          = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (ic_flush_i) begin
          flushed_d = 1'b1;
        end
        if (mem_rsp_valid_i) begin
          ram_we = 1'b1;
          beat_d = beat_q + OFF_W'(1);
          if (beat_q == BEAT_LAST) begin
            if (flushed_q || ic_flush_i) begin
              state_d = ST_IDLE;
            end else begin
              valid_d[req_idx] = 1'b1;
              tag_we           = 1'b1;
              state_d          = ST_RESP;
            end
          end
        end
      end
      ST_RESP: begin
        rsp_valid = !ic_flush_i;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ic_flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      flushed_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      flushed_q <= flushed_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_we) begin
      tag_q[req_idx] <= req_tag;
    end
  end

  icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (RAM_AW)
  ) u_data_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i ({req_idx, beat_q}),
    .wdata_i (mem_rsp_data_i),
    .raddr_i ({req_idx, req_off}),
    .rdata_o (ram_rdata)
  );

  assign ic_req_ready_o  = ready;
  assign ic_rsp_valid_o  = rsp_valid;
  assign ic_rsp_data_o   = rsp_valid ? ram_rdata : '0;
  assign mem_req_valid_o = mem_req_valid;
  assign mem_req_addr_o  = mem_req_valid ? {req_tag, req_idx, {(OFF_W + 2){1'b0}}} : '0;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        lookup_live;

  assign lookup_live = (state_q == ST_LOOKUP) && !ic_flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_live && hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (lookup_live && !hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
